trace_capture_buffer: RTL and testbench
=======================================

TRACE_CAPTURE_BUFFER -- requirements
Module: trace_capture_buffer

Interface
REQ-001 SHALL have parameter Fpay, default 32, meaning trace word width per channel.
REQ-002 SHALL have parameter Tile_num, default 4, meaning number of traced channels (>=2).
REQ-003 SHALL have parameter TB_Depth, default 512, meaning buffer entries (power of two, >=4); Dw=log2(TB_Depth), Cw=log2(Tile_num).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port din, input, Tile_num*Fpay, channel i word at [i*Fpay +: Fpay].
REQ-007 SHALL have port wr_req, input, Tile_num, per-channel write request.
REQ-008 SHALL have port ch_en, input, Tile_num, channel enable mask; disabled requests are ignored, not counted.
REQ-009 SHALL have ports arm, trigger, circular, inputs, 1 each: start capture, trigger event, 1=wrap/overwrite mode.
REQ-010 SHALL have port post_trig_cnt, input, Dw, entries to record after trigger.
REQ-011 SHALL have port rd_en, input, 1, readout pop request.
REQ-012 SHALL have ports dout (Fpay), dout_ch (Cw), dout_valid (1), outputs, read word, source channel, valid strobe.
REQ-013 SHALL have ports state (2), depth (Dw+1), empty, full, wrapped (1 each), drop_cnt (16), trig_addr (Dw), all outputs.

Function
REQ-014 SHALL implement states IDLE=0, ARMED=1, POST=2, DONE=3, output on state.
REQ-015 SHALL, on arm in IDLE or DONE, clear pointers, depth, wrapped, drop_cnt and enter ARMED next cycle; arm in ARMED/POST is ignored.
REQ-016 SHALL, in ARMED/POST, grant at most one enabled requesting channel per cycle via round-robin (priority starts after last granted channel; after reset after channel Tile_num-1, i.e. channel 0 highest).
REQ-017 SHALL increment drop_cnt, saturating at 0xFFFF, once per enabled requesting channel not granted in a cycle in ARMED/POST.
REQ-018 SHALL store the granted word plus its channel index at wr_ptr, advance wr_ptr modulo TB_Depth, and increment depth.
REQ-019 SHALL, when full and circular=1, overwrite the oldest entry: wr_ptr and rd_ptr both advance, depth stays TB_Depth, wrapped set sticky.
REQ-020 SHALL, when the write that makes depth=TB_Depth occurs with circular=0, enter DONE next cycle; no further writes are accepted.
REQ-021 SHALL, on trigger in ARMED, latch wr_ptr of the next write slot into trig_addr, load post counter with post_trig_cnt, and enter POST (or DONE if post_trig_cnt=0); a write in the trigger cycle counts as pre-trigger.
REQ-022 SHALL, in POST, decrement the post counter per accepted write and enter DONE the cycle after the write bringing it to 0; trigger in POST/DONE/IDLE is ignored.
REQ-023 SHALL accept rd_en only in DONE with empty=0; accepted read drives dout/dout_ch with dout_valid=1 exactly one cycle later, then advances rd_ptr and decrements depth.
REQ-024 SHALL ignore rd_en when empty or outside DONE (dout_valid=0, no pointer change).
REQ-025 SHALL drive empty=(depth==0), full=(depth==TB_Depth) combinationally from depth.

Reset
REQ-026 SHALL on reset set state=IDLE, pointers=0, depth=0, drop_cnt=0, trig_addr=0, wrapped=0, dout=0, dout_ch=0, dout_valid=0, round-robin pointer to channel Tile_num-1.
REQ-027 SHALL let reset override arm, trigger, writes and reads in the same cycle, including mid-POST.

Structure
REQ-028 SHALL place state encoding enum and a log2 function in shared package trace_pkg.
REQ-029 SHALL instantiate one sub-module trace_ram: simple dual-port, Fpay+Cw wide, TB_Depth deep, registered read.

Verification (TB_Depth=8, Tile_num=4, Fpay=32)
REQ-030 Reset: assert reset 2 cycles -> state=0, depth=0, empty=1, drop_cnt=0, dout_valid=0.
REQ-031 circular=0, arm, ch2 writes 0x1..0x8 -> full=1, state=DONE; 8 reads return 0x1..0x8, dout_ch=2, then empty=1; 9th rd_en gives dout_valid=0.
REQ-032 circular=1, ch1 writes 0x1..0xC, trigger with post_trig_cnt=0 on 12th write -> DONE, depth=8, wrapped=1, reads 0x5..0xC.
REQ-033 circular=1, 2 writes, trigger with post_trig_cnt=3, 5 more writes -> DONE after 5th total, depth=5, trig_addr=2, last 2 writes not stored.
REQ-034 ch0 and ch3 request 4 consecutive cycles -> stored order ch0,ch3,ch0,ch3, drop_cnt=4.
REQ-035 Reset asserted in POST with depth=3 -> next cycle state=IDLE, depth=0, rd_en ignored.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and helpers for the trace capture buffer.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
module trace_ram #(
  parameter int W     = 34,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/trace_capture_buffer.sv
// Multi-channel trace capture: round-robin arbitration into a trace RAM,
// with linear or circular capture, post-trigger window and DONE-state readout.
module trace_capture_buffer
  import trace_pkg::*;
#(
  parameter int Fpay     = 32,
  parameter int Tile_num = 4,
  parameter int TB_Depth = 512,
  localparam int Dw      = clog2(TB_Depth),
  localparam int Cw      = clog2(Tile_num)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [Tile_num*Fpay-1:0] din,
  input  logic [Tile_num-1:0]      wr_req,
  input  logic [Tile_num-1:0]      ch_en,
  input  logic                     arm,
  input  logic                     trigger,
  input  logic                     circular,
  input  logic [Dw-1:0]            post_trig_cnt,
  input  logic                     rd_en,
  output logic [Fpay-1:0]          dout,
  output logic [Cw-1:0]            dout_ch,
  output logic                     dout_valid,
  output logic [1:0]               state,
  output logic [Dw:0]              depth,
  output logic                     empty,
  output logic                     full,
  output logic                     wrapped,
  output logic [15:0]              drop_cnt,
  output logic [Dw-1:0]            trig_addr
);

  localparam logic [Dw:0] FULL_DEPTH = (Dw+1)'(TB_Depth);
  localparam logic [Dw:0] LAST_FREE  = (Dw+1)'(TB_Depth - 1);

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input int b);
    int s;
    s = int'(a) + b;
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  trace_state_e  state_q, state_d;
  logic [Dw-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Dw:0]   depth_q, depth_d;
  logic          wrapped_q, wrapped_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [Dw-1:0] trig_addr_q, trig_addr_d;
  logic [Dw-1:0] post_cnt_q, post_cnt_d;
  logic [Cw-1:0] rr_last_q, rr_last_d;
  logic          dout_valid_q, dout_valid_d;

  logic [Tile_num-1:0] req_en;
  logic                gnt_vld, capture, wr_acc, rd_acc, fills_last;
  logic [Cw-1:0]       gnt_idx;
  int                  n_req, idx;
  logic [Fpay+Cw-1:0]  ram_rdata;

  assign req_en  = wr_req & ch_en;
  assign empty   = (depth_q == '0);
  assign full    = (depth_q == FULL_DEPTH);
  assign capture = (state_q == ST_ARMED) || (state_q == ST_POST);

  // Round-robin: search starts just after the last granted channel.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr_last_q;
    n_req   = 0;
    idx     = 0;
    for (int k = 1; k <= Tile_num; k++) begin
      idx = (int'(rr_last_q) + k) % Tile_num;
      if (!gnt_vld && req_en[Cw'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = Cw'(idx);
      end
    end
    for (int i = 0; i < Tile_num; i++) begin
      if (req_en[Cw'(i)]) n_req++;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    depth_d      = depth_q;
    wrapped_d    = wrapped_q;
    drop_cnt_d   = drop_cnt_q;
    trig_addr_d  = trig_addr_q;
    post_cnt_d   = post_cnt_q;
    rr_last_d    = rr_last_q;
    wr_acc       = capture && gnt_vld && (!full || circular);
    rd_acc       = (state_q == ST_DONE) && rd_en && !empty && !arm;
    fills_last   = wr_acc && !circular && (depth_q == LAST_FREE);
    dout_valid_d = rd_acc;

    if (capture && gnt_vld) begin
      drop_cnt_d = sat_add16(drop_cnt_q, n_req - 1);
      rr_last_d  = gnt_idx;
    end

    // A write into a full circular buffer evicts the oldest entry.
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (full) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        wrapped_d = 1'b1;
      end else begin
        depth_d = depth_q + 1'b1;
      end
    end

    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      depth_d  = depth_q - 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_d    = ST_ARMED;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          depth_d    = '0;
          wrapped_d  = 1'b0;
          drop_cnt_d = '0;
        end
      end
      ST_ARMED: begin
        if (fills_last) begin
          state_d = ST_DONE;
        end else if (trigger) begin
          trig_addr_d = wr_ptr_d;
          post_cnt_d  = post_trig_cnt;
          state_d     = (post_trig_cnt == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (wr_acc) begin
          post_cnt_d = post_cnt_q - 1'b1;
          if (fills_last || post_cnt_q == Dw'(1)) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      depth_q      <= '0;
      wrapped_q    <= 1'b0;
      drop_cnt_q   <= '0;
      trig_addr_q  <= '0;
      post_cnt_q   <= '0;
      rr_last_q    <= Cw'(Tile_num - 1);
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      depth_q      <= depth_d;
      wrapped_q    <= wrapped_d;
      drop_cnt_q   <= drop_cnt_d;
      trig_addr_q  <= trig_addr_d;
      post_cnt_q   <= post_cnt_d;
      rr_last_q    <= rr_last_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  trace_ram #(
    .W     (Fpay + Cw),
    .DEPTH (TB_Depth),
    .AW    (Dw)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc && !reset),
    .waddr (wr_ptr_q),
    .wdata ({gnt_idx, din[int'(gnt_idx)*Fpay +: Fpay]}),
    .re    (rd_acc && !reset),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Read data is only presented while the valid strobe is high.
  assign dout       = dout_valid_q ? ram_rdata[Fpay-1:0] : '0;
  assign dout_ch    = dout_valid_q ? ram_rdata[Fpay+Cw-1:Fpay] : '0;
  assign dout_valid = dout_valid_q;
  assign state      = state_q;
  assign depth      = depth_q;
  assign wrapped    = wrapped_q;
  assign drop_cnt   = drop_cnt_q;
  assign trig_addr  = trig_addr_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer with TB_Depth=8, Tile_num=4, Fpay=32.
module tb_trace_capture_buffer;

  localparam int FP = 32;
  localparam int TN = 4;
  localparam int TD = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [TN*FP-1:0] din;
  logic [TN-1:0]  wr_req;
  logic [TN-1:0]  ch_en;
  logic           arm, trigger, circular;
  logic [2:0]     post_trig_cnt;
  logic           rd_en;
  logic [FP-1:0]  dout;
  logic [1:0]     dout_ch;
  logic           dout_valid;
  logic [1:0]     state;
  logic [3:0]     depth;
  logic           empty, full, wrapped;
  logic [15:0]    drop_cnt;
  logic [2:0]     trig_addr;

  int passed = 0;
  int total  = 0;

  trace_capture_buffer #(.Fpay(FP), .Tile_num(TN), .TB_Depth(TD)) dut (
    .clk(clk), .reset(reset), .din(din), .wr_req(wr_req), .ch_en(ch_en),
    .arm(arm), .trigger(trigger), .circular(circular),
    .post_trig_cnt(post_trig_cnt), .rd_en(rd_en), .dout(dout),
    .dout_ch(dout_ch), .dout_valid(dout_valid), .state(state), .depth(depth),
    .empty(empty), .full(full), .wrapped(wrapped), .drop_cnt(drop_cnt),
    .trig_addr(trig_addr)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    din = '0; wr_req = '0; ch_en = 4'hF; arm = 0; trigger = 0;
    post_trig_cnt = '0; rd_en = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    circular = 0;
    reset = 1;
    cycle();
    cycle();
    reset = 0;
    total++; if (state !== 2'd0) $display("FAIL reset_state got %0d want 0", state); else passed++;
    total++; if (depth !== 4'd0) $display("FAIL reset_depth got %0d want 0", depth); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL reset_empty got %0b want 1", empty); else passed++;
    total++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop got %0d want 0", drop_cnt); else passed++;
    total++; if (dout_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", dout_valid); else passed++;
  endtask

  task automatic test_linear_fill();
    circular = 0;
    arm = 1; cycle(); arm = 0;
    total++; if (state !== 2'd1) $display("FAIL lin_armed got %0d want 1", state); else passed++;
    for (int i = 1; i <= 8; i++) begin
      wr_req = 4'b0100; din = '0; din[2*FP +: FP] = i;
      cycle();
    end
    wr_req = '0;
    total++; if (full !== 1'b1) $display("FAIL lin_full got %0b want 1", full); else passed++;
    total++; if (state !== 2'd3) $display("FAIL lin_done got %0d want 3", state); else passed++;
    rd_en = 1;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      total++; if (dout_valid !== 1'b1) $display("FAIL lin_rd%0d_valid got %0b want 1", i, dout_valid); else passed++;
      total++; if (dout !== FP'(i)) $display("FAIL lin_rd%0d_data got %0h want %0h", i, dout, i); else passed++;
      total++; if (dout_ch !== 2'd2) $display("FAIL lin_rd%0d_ch got %0d want 2", i, dout_ch); else passed++;
    end
    total++; if (empty !== 1'b1) $display("FAIL lin_empty got %0b want 1", empty); else passed++;
    cycle();
    rd_en = 0;
    total++; if (dout_valid !== 1'b0) $display("FAIL lin_rd9_valid got %0b want 0", dout_valid); else passed++;
  endtask

  task automatic test_circular_wrap();
    circular = 1;
    arm = 1; cycle(); arm = 0;
    total++; if (depth !== 4'd0) $display("FAIL circ_cleared got %0d want 0", depth); else passed++;
    for (int i = 1; i <= 12; i++) begin
      wr_req = 4'b0010; din = '0; din[FP +: FP] = i;
      trigger = (i == 12); post_trig_cnt = '0;
      cycle();
    end
    wr_req = '0; trigger = 0;
    total++; if (state !== 2'd3) $display("FAIL circ_done got %0d want 3", state); else passed++;
    total++; if (depth !== 4'd8) $display("FAIL circ_depth got %0d want 8", depth); else passed++;
    total++; if (wrapped !== 1'b1) $display("FAIL circ_wrapped got %0b want 1", wrapped); else passed++;
    rd_en = 1;
    for (int i = 5; i <= 12; i++) begin
      cycle();
      total++; if (dout !== FP'(i) || dout_ch !== 2'd1 || dout_valid !== 1'b1)
        $display("FAIL circ_rd got %0h/ch%0d/v%0b want %0h/ch1/v1", dout, dout_ch, dout_valid, i);
      else passed++;
    end
    rd_en = 0;
    cycle();
  endtask

  task automatic test_post_trigger();
    circular = 1;
    arm = 1; cycle(); arm = 0;
    for (int i = 1; i <= 2; i++) begin
      wr_req = 4'b0100; din = '0; din[2*FP +: FP] = 32'hA0 + i;
      cycle();
    end
    wr_req = '0; trigger = 1; post_trig_cnt = 3'd3;
    cycle();
    trigger = 0; post_trig_cnt = '0;
    total++; if (state !== 2'd2) $display("FAIL post_state got %0d want 2", state); else passed++;
    total++; if (trig_addr !== 3'd2) $display("FAIL post_trig_addr got %0d want 2", trig_addr); else passed++;
    for (int i = 3; i <= 7; i++) begin
      wr_req = 4'b0100; din = '0; din[2*FP +: FP] = 32'hA0 + i;
      cycle();
      if (i == 5) begin
        total++; if (state !== 2'd3) $display("FAIL post_done_at5 got %0d want 3", state); else passed++;
      end
    end
    wr_req = '0;
    total++; if (depth !== 4'd5) $display("FAIL post_depth got %0d want 5", depth); else passed++;
    total++; if (trig_addr !== 3'd2) $display("FAIL post_trig_hold got %0d want 2", trig_addr); else passed++;
    rd_en = 1;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      total++; if (dout !== 32'hA0 + i || dout_valid !== 1'b1)
        $display("FAIL post_rd got %0h/v%0b want %0h/v1", dout, dout_valid, 32'hA0 + i);
      else passed++;
    end
    rd_en = 0;
    total++; if (empty !== 1'b1) $display("FAIL post_empty got %0b want 1", empty); else passed++;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_d [4];
    logic [1:0]  exp_c [4];
    exp_d[0] = 32'h10; exp_c[0] = 2'd0;
    exp_d[1] = 32'h31; exp_c[1] = 2'd3;
    exp_d[2] = 32'h12; exp_c[2] = 2'd0;
    exp_d[3] = 32'h33; exp_c[3] = 2'd3;
    idle_inputs();
    circular = 0;
    reset = 1; cycle(); reset = 0;
    arm = 1; cycle(); arm = 0;
    wr_req = 4'b0010; ch_en = 4'b1101;
    cycle();
    ch_en = 4'hF;
    total++; if (depth !== 4'd0 || drop_cnt !== 16'd0)
      $display("FAIL rr_masked got depth %0d drop %0d want 0 0", depth, drop_cnt);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      wr_req = 4'b1001; din = '0;
      din[0 +: FP] = 32'h10 + i;
      din[3*FP +: FP] = 32'h30 + i;
      cycle();
    end
    wr_req = '0;
    total++; if (drop_cnt !== 16'd4) $display("FAIL rr_drop got %0d want 4", drop_cnt); else passed++;
    total++; if (depth !== 4'd4) $display("FAIL rr_depth got %0d want 4", depth); else passed++;
    trigger = 1; cycle(); trigger = 0;
    total++; if (state !== 2'd3) $display("FAIL rr_done got %0d want 3", state); else passed++;
    rd_en = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      total++; if (dout !== exp_d[i] || dout_ch !== exp_c[i])
        $display("FAIL rr_order%0d got %0h/ch%0d want %0h/ch%0d", i, dout, dout_ch, exp_d[i], exp_c[i]);
      else passed++;
    end
    rd_en = 0;
  endtask

  task automatic test_reset_mid_post();
    idle_inputs();
    circular = 0;
    reset = 1; cycle(); reset = 0;
    arm = 1; cycle(); arm = 0;
    for (int i = 1; i <= 3; i++) begin
      wr_req = 4'b0010; din = '0; din[FP +: FP] = 32'h50 + i;
      cycle();
    end
    wr_req = '0; trigger = 1; post_trig_cnt = 3'd5;
    cycle();
    trigger = 0; post_trig_cnt = '0;
    total++; if (state !== 2'd2 || depth !== 4'd3)
      $display("FAIL mid_pre got state %0d depth %0d want 2 3", state, depth);
    else passed++;
    reset = 1; rd_en = 1; wr_req = 4'b0010;
    cycle();
    reset = 0; wr_req = '0;
    total++; if (state !== 2'd0) $display("FAIL mid_state got %0d want 0", state); else passed++;
    total++; if (depth !== 4'd0) $display("FAIL mid_depth got %0d want 0", depth); else passed++;
    cycle();
    rd_en = 0;
    total++; if (dout_valid !== 1'b0 || depth !== 4'd0)
      $display("FAIL mid_rd_ignored got v%0b depth %0d want v0 depth 0", dout_valid, depth);
    else passed++;
  endtask

  initial begin
    reset = 1; circular = 0;
    idle_inputs();
    test_reset();
    test_linear_fill();
    test_circular_wrap();
    test_post_trigger();
    test_round_robin();
    test_reset_mid_post();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
